// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a 256-bit cache line port to a BEATS-beat 64-bit burst memory.
module cacheline_adaptor #(
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [64*BEATS-1:0]   line_i,
  output logic [64*BEATS-1:0]   line_o,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [63:0]           burst_i,
  output logic [63:0]           burst_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [31:0]         r_addr;
  logic [64*BEATS-1:0] r_line;
  logic [64*BEATS-1:0] r_wline;
  logic                w_last;
  logic [CW+5:0]       w_base;
  logic [CW+5:0]       w_wbase;
  assign w_last  = r_cnt == CW'(BEATS - 1);
  assign w_base  = {r_cnt, 6'd0};
  // outside WRITE the memory sees beat 0 of the latched line
  assign w_wbase = r_state == WRITE ? w_base : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_line  <= '0;
      r_wline <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i) begin
            r_addr  <= address_i;
            r_cnt   <= '0;
            r_state <= READ;
          end else if (write_i) begin
            r_addr  <= address_i;
            r_wline <= line_i;
            r_cnt   <= '0;
            r_state <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            r_line[w_base +: 64] <= burst_i;
            r_cnt                <= r_cnt + 1'b1;
            r_state              <= w_last ? DONE : READ;
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= w_last ? DONE : WRITE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign read_o    = r_state == READ;
  assign write_o   = r_state == WRITE;
  assign resp_o    = r_state == DONE;
  assign address_o = r_addr;
  assign line_o    = r_line;
  assign burst_o   = r_wline[w_wbase +: 64];
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: randomized self-checking bench against a transaction-level model.
module tb_cacheline_adaptor;
  logic         clk = 0;
  logic         rst = 1;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 0;
  logic         write_i = 0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 0;
  int           checks = 0;
  int           failures = 0;
  logic [255:0] m_line = '0;
  cacheline_adaptor #(.BEATS(4)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(negedge clk);
  endtask
  function automatic logic [255:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic do_read(input logic [31:0] a, input logic [255:0] d, input int maxgap,
                         input bit both, input bit hold);
    read_i = 1; write_i = both; address_i = a; line_i = rnd_line();
    cyc();
    read_i = hold; write_i = 0; address_i = $urandom;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b100) begin
      failures++; $display("FAIL rd_start rwr=%b want 100", {read_o, write_o, resp_o});
    end
    checks++;
    if (address_o !== a) begin
      failures++; $display("FAIL rd_addr got %h want %h", address_o, a);
    end
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(maxgap, 0)) begin
        resp_i = 0; burst_i = {$urandom, $urandom};
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b100) begin
          failures++; $display("FAIL rd_wait rwr=%b want 100", {read_o, write_o, resp_o});
        end
        cyc();
      end
      resp_i = 1; burst_i = d[64*i +: 64];
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b100) begin
        failures++; $display("FAIL rd_beat%0d rwr=%b want 100", i, {read_o, write_o, resp_o});
      end
      cyc();
    end
    m_line = d;
    resp_i = $urandom; burst_i = {$urandom, $urandom};
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      failures++; $display("FAIL rd_done rwr=%b want 001", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== m_line) begin
      failures++; $display("FAIL rd_line got %h want %h", line_o, m_line);
    end
    cyc();
    resp_i = 0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++; $display("FAIL rd_idle rwr=%b want 000", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== m_line) begin
      failures++; $display("FAIL rd_hold got %h want %h", line_o, m_line);
    end
  endtask
  task automatic do_write(input logic [31:0] a, input logic [255:0] d,
                          input logic [31:0] p, input int n);
    int k;
    write_i = 1; read_i = 0; address_i = a; line_i = d;
    cyc();
    write_i = 0; line_i = rnd_line(); address_i = $urandom;
    k = 0;
    for (int j = 0; j < n; j++) begin
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b010) begin
        failures++; $display("FAIL wr_active rwr=%b want 010", {read_o, write_o, resp_o});
      end
      checks++;
      if (burst_o !== d[64*k +: 64]) begin
        failures++; $display("FAIL wr_burst%0d got %h want %h", k, burst_o, d[64*k +: 64]);
      end
      checks++;
      if (address_o !== a) begin
        failures++; $display("FAIL wr_addr got %h want %h", address_o, a);
      end
      resp_i = p[j]; burst_i = {$urandom, $urandom};
      cyc();
      if (p[j]) k++;
    end
    resp_i = 0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      failures++; $display("FAIL wr_done rwr=%b want 001", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== m_line) begin
      failures++; $display("FAIL wr_line_kept got %h want %h", line_o, m_line);
    end
    checks++;
    if (burst_o !== d[63:0]) begin
      failures++; $display("FAIL wr_idle_burst got %h want %h", burst_o, d[63:0]);
    end
    cyc();
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++; $display("FAIL wr_idle rwr=%b want 000", {read_o, write_o, resp_o});
    end
  endtask
  task automatic test_reset();
    rst = 1; read_i = 1; write_i = 1; resp_i = 1; address_i = 32'hFFFF_FFE0; line_i = rnd_line();
    cyc();
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000 || burst_o !== 64'd0) begin
      failures++; $display("FAIL reset_ctrl rwr=%b burst=%h want 000/0", {read_o, write_o, resp_o}, burst_o);
    end
    checks++;
    if (line_o !== 256'd0 || address_o !== 32'd0) begin
      failures++; $display("FAIL reset_data line=%h addr=%h want 0", line_o, address_o);
    end
    rst = 0; read_i = 0; write_i = 0; resp_i = 0;
    cyc();
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++; $display("FAIL reset_idle rwr=%b want 000", {read_o, write_o, resp_o});
    end
  endtask
  task automatic test_read_b2b();
    do_read(32'h0000_1A20, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 0, 0);
  endtask
  task automatic test_write_gaps();
    do_write(32'h0000_2B40, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 32'b1011001, 7);
  endtask
  task automatic test_read_write_collision();
    do_read(32'h0000_3C60, rnd_line(), 2, 1, 0);
  endtask
  task automatic test_reset_mid_read();
    read_i = 1; address_i = 32'h0000_4D80;
    cyc();
    read_i = 0;
    for (int i = 0; i < 2; i++) begin
      resp_i = 1; burst_i = {$urandom, $urandom};
      cyc();
    end
    rst = 1; resp_i = 1; read_i = 1; write_i = 1;
    cyc();
    rst = 0; resp_i = 0; read_i = 0; write_i = 0;
    m_line = '0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000 || burst_o !== 64'd0) begin
      failures++; $display("FAIL abort_ctrl rwr=%b burst=%h want 000/0", {read_o, write_o, resp_o}, burst_o);
    end
    checks++;
    if (line_o !== m_line || address_o !== 32'd0) begin
      failures++; $display("FAIL abort_data line=%h addr=%h want 0", line_o, address_o);
    end
    repeat (3) begin
      checks++;
      if (resp_o !== 1'b0) begin
        failures++; $display("FAIL abort_resp got %b want 0", resp_o);
      end
      cyc();
    end
    do_read(32'h0000_4DA0, rnd_line(), 1, 0, 0);
  endtask
  task automatic test_stray_and_hold();
    repeat (3) begin
      resp_i = 1; burst_i = {$urandom, $urandom};
      cyc();
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== m_line) begin
        failures++; $display("FAIL stray_resp rwr=%b line=%h want 000/%h", {read_o, write_o, resp_o}, line_o, m_line);
      end
    end
    resp_i = 0;
    do_read(32'h0000_5E00, rnd_line(), 1, 0, 1);
    do_read(32'h0000_5E20, rnd_line(), 1, 0, 0);
  endtask
  task automatic test_random();
    logic [31:0] p;
    int n;
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        do_read({$urandom, 5'd0} , rnd_line(), 2, $urandom_range(1, 0), 0);
      end else begin
        p = '0; n = 0;
        for (int b = 0; b < 4; b++) begin
          n += $urandom_range(2, 0);
          p[n] = 1'b1;
          n++;
        end
        do_write({$urandom, 5'd0}, rnd_line(), p, n);
      end
      repeat ($urandom_range(2, 0)) cyc();
    end
  endtask
  initial begin
    test_reset();
    test_read_b2b();
    test_write_gaps();
    test_read_write_collision();
    test_reset_mid_read();
    test_stray_and_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
